// File: rtl/pll_seq_pkg.sv
// Shared types and constants for the LPDDR2 PLL reset sequencer.
// State encodings are visible on state_o, so they are fixed here.
package pll_seq_pkg;

    typedef enum logic [2:0] {
        ST_RESET_HOLD = 3'd0,
        ST_WAIT_LOCK  = 3'd1,
        ST_STABILIZE  = 3'd2,
        ST_RUN        = 3'd3,
        ST_FAIL       = 3'd4
    } pll_state_e;

    localparam int LOCK_LOSS_CNT_W = 8;

    function automatic int max2(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/sync_2ff.sv
// 1-bit two-flop synchronizer with asynchronous active-low reset.
// Output is zero while in reset.
module sync_2ff (
    input  logic clk,
    input  logic rst_n,
    input  logic d,
    output logic q
);

    logic meta;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            meta <= 1'b0;
            q    <= 1'b0;
        end else begin
            meta <= d;
            q    <= meta;
        end
    end

endmodule

// File: rtl/pll_reset_sequencer.sv
// PLL reset/lock sequencer for the LPDDR2 clocking PLL (refclk domain).
// Optional RUN-state lock-loss glitch filter: PLL_SEQ_LOCK_LOSS_FILTER_EN.
module pll_reset_sequencer
    import pll_seq_pkg::*;
#(
    parameter int RST_HOLD_CYCLES     = 64,
    parameter int LOCK_TIMEOUT_CYCLES = 125000,
    parameter int LOCK_STABLE_CYCLES  = 1024,
    parameter int MAX_RETRIES         = 4,
    parameter int LOSS_FILTER_CYCLES  = 8
) (
    input  logic                       refclk,
    input  logic                       rst_n,
    input  logic                       pll_locked,
    input  logic                       soft_reset_req,
    output logic                       pll_rst,
    output logic                       ctrl_rst_n,
    output logic                       pll_ready,
    output logic                       pll_fail,
    output logic [2:0]                 state_o,
    output logic [LOCK_LOSS_CNT_W-1:0] lock_loss_cnt
);

    localparam int MAX_CYC = max2(max2(RST_HOLD_CYCLES, LOCK_TIMEOUT_CYCLES),
                                  max2(LOCK_STABLE_CYCLES, LOSS_FILTER_CYCLES));
    localparam int TW = (MAX_CYC > 1) ? $clog2(MAX_CYC) : 1;
    localparam int RW = $clog2(MAX_RETRIES + 1);

    localparam logic [TW-1:0] HOLD_LAST    = TW'(RST_HOLD_CYCLES - 1);
    localparam logic [TW-1:0] TIMEOUT_LAST = TW'(LOCK_TIMEOUT_CYCLES - 1);
    localparam logic [TW-1:0] STABLE_LAST  = TW'(LOCK_STABLE_CYCLES - 1);
    localparam logic [RW-1:0] RETRY_LIMIT  = RW'(MAX_RETRIES);

    pll_state_e                 state_q, state_d;
    logic [TW-1:0]              timer_q, timer_d;
    logic [RW-1:0]              retry_q, retry_d;
    logic [LOCK_LOSS_CNT_W-1:0] loss_q, loss_d;
    logic                       lock_s;
    logic                       loss_evt;

    sync_2ff u_lock_sync (
        .clk   (refclk),
        .rst_n (rst_n),
        .d     (pll_locked),
        .q     (lock_s)
    );

`ifdef PLL_SEQ_LOCK_LOSS_FILTER_EN
    localparam int FW = (LOSS_FILTER_CYCLES > 1) ? $clog2(LOSS_FILTER_CYCLES) : 1;
    localparam logic [FW-1:0] FILT_LAST = FW'(LOSS_FILTER_CYCLES - 1);

    logic [FW-1:0] filt_q;

    assign loss_evt = (state_q == ST_RUN) && !lock_s && (filt_q == FILT_LAST);

    // Counts consecutive low lock_s cycles in RUN; any high sample restarts it.
    always_ff @(posedge refclk or negedge rst_n) begin
        if (!rst_n) begin
            filt_q <= '0;
        end else if (state_q != ST_RUN || lock_s || state_d != ST_RUN) begin
            filt_q <= '0;
        end else begin
            filt_q <= filt_q + FW'(1);
        end
    end
`else
    assign loss_evt = (state_q == ST_RUN) && !lock_s;
`endif

    always_ff @(posedge refclk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_RESET_HOLD;
            timer_q <= '0;
            retry_q <= '0;
            loss_q  <= '0;
        end else begin
            state_q <= state_d;
            timer_q <= timer_d;
            retry_q <= retry_d;
            loss_q  <= loss_d;
        end
    end

    always_comb begin
        state_d = state_q;
        retry_d = retry_q;
        loss_d  = loss_q;
        if (soft_reset_req) begin
            state_d = ST_RESET_HOLD;
            retry_d = '0;
        end else begin
            unique case (state_q)
                ST_RESET_HOLD: begin
                    if (timer_q == HOLD_LAST) state_d = ST_WAIT_LOCK;
                end
                ST_WAIT_LOCK: begin
                    if (lock_s) begin
                        state_d = ST_STABILIZE;
                    end else if (timer_q == TIMEOUT_LAST) begin
                        retry_d = retry_q + RW'(1);
                        state_d = (retry_d == RETRY_LIMIT) ? ST_FAIL
                                                           : ST_RESET_HOLD;
                    end
                end
                ST_STABILIZE: begin
                    if (!lock_s) begin
                        state_d = ST_WAIT_LOCK;
                    end else if (timer_q == STABLE_LAST) begin
                        state_d = ST_RUN;
                        retry_d = '0;
                    end
                end
                ST_RUN: begin
                    if (loss_evt) begin
                        state_d = ST_RESET_HOLD;
                        if (loss_q != '1) loss_d = loss_q + LOCK_LOSS_CNT_W'(1);
                    end
                end
                ST_FAIL: ;
                default: state_d = ST_RESET_HOLD;
            endcase
        end

        // Soft reset in RESET_HOLD keeps the state but must restart the hold.
        timer_d = timer_q;
        if (soft_reset_req || state_d != state_q) begin
            timer_d = '0;
        end else if (state_q == ST_RESET_HOLD || state_q == ST_WAIT_LOCK ||
                     (state_q == ST_STABILIZE && lock_s)) begin
            timer_d = timer_q + TW'(1);
        end
    end

    always_comb begin
        pll_rst       = (state_q == ST_RESET_HOLD);
        ctrl_rst_n    = (state_q == ST_RUN);
        pll_ready     = (state_q == ST_RUN);
        pll_fail      = (state_q == ST_FAIL);
        state_o       = state_q;
        lock_loss_cnt = loss_q;
    end

endmodule
